// File: rtl/cpu_sequencer_if.sv
// Datapath-facing bus of cpu_sequencer: fetch address, instruction word,
// decoded fields and the write/capture strobes.
interface cpu_sequencer_if #(
   parameter int PC_WIDTH = 5
);
   logic [PC_WIDTH-1:0] pc;
   logic [31:0]         instruction;
   logic [31:0]         ir;
   logic [2:0]          alu_op;
   logic [4:0]          rd;
   logic                rf_we;
   logic                result_load;

   modport master (
      output pc, ir, rf_we, result_load,
      input  instruction, alu_op, rd
   );

   modport slave (
      input  pc, ir, rf_we, result_load,
      output instruction, alu_op, rd
   );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer with single-step and free-run.
// Optional breakpoint logic is enabled by defining CPU_SEQ_BREAKPOINT_EN.
module cpu_sequencer #(
   parameter int PC_WIDTH  = 5,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 control,
   input  logic                 run,
`ifdef CPU_SEQ_BREAKPOINT_EN
   input  logic                 bp_en,
   input  logic [PC_WIDTH-1:0]  bp_addr,
   output logic                 bp_hit,
`endif
   cpu_sequencer_if.master      dp,
   output logic [2:0]           state,
   output logic                 halted,
   output logic [CNT_WIDTH-1:0] instr_count
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_DECODE    = 3'd2,
      ST_EXECUTE   = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_HALT      = 3'd5
   } state_t;

   state_t               state_r;
   logic [PC_WIDTH-1:0]  pc_r;
   logic [31:0]          ir_r;
   logic                 halted_r;
   logic [CNT_WIDTH-1:0] count_r;
   logic                 ctl_d_r;

   logic [PC_WIDTH-1:0]  next_pc_s;
   logic                 step_s;
   logic                 write_ok_s;
   logic                 bp_stop_s;
   logic                 rf_we_s;
   logic                 result_load_s;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      if (&v) begin
         return v;
      end else begin
         return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   endfunction

   // Step-edge detect, write qualification and reset-gated strobes
   always_comb begin
      next_pc_s  = pc_r + {{(PC_WIDTH-1){1'b0}}, 1'b1};
      step_s     = control & ~ctl_d_r;
      write_ok_s = (dp.alu_op != 3'd0) && (dp.rd != 5'd0);
`ifdef CPU_SEQ_BREAKPOINT_EN
      bp_stop_s  = bp_en && (next_pc_s == bp_addr);
`else
      bp_stop_s  = 1'b0;
`endif
      if (!reset) begin
         rf_we_s       = 1'b0;
         result_load_s = 1'b0;
      end else begin
         rf_we_s       = (state_r == ST_WRITEBACK) && write_ok_s;
         result_load_s = (state_r == ST_EXECUTE);
      end
   end

   // Sequencer state, program counter, instruction register and retire counter
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r  <= ST_IDLE;
         pc_r     <= {PC_WIDTH{1'b0}};
         ir_r     <= 32'h0000_0000;
         halted_r <= 1'b0;
         count_r  <= {CNT_WIDTH{1'b0}};
         ctl_d_r  <= 1'b0;
      end else begin
         // Tracks the level in every state so a held button never re-steps
         ctl_d_r <= control;
         case (state_r)
            ST_IDLE: begin
               if (step_s || run) begin
                  state_r <= ST_FETCH;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_FETCH: begin
               if (dp.instruction == 32'h0000_0000) begin
                  state_r  <= ST_HALT;
                  halted_r <= 1'b1;
               end else begin
                  ir_r    <= dp.instruction;
                  state_r <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               state_r <= ST_EXECUTE;
            end
            ST_EXECUTE: begin
               state_r <= ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
               pc_r    <= next_pc_s;
               count_r <= sat_inc(count_r);
               if (run && !bp_stop_s) begin
                  state_r <= ST_FETCH;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_HALT: begin
               state_r  <= ST_HALT;
               halted_r <= 1'b1;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign dp.pc          = pc_r;
   assign dp.ir          = ir_r;
   assign dp.rf_we       = rf_we_s;
   assign dp.result_load = result_load_s;
   assign state          = state_r;
   assign halted         = halted_r;
   assign instr_count    = count_r;

`ifdef CPU_SEQ_BREAKPOINT_EN
   assign bp_hit = reset && (state_r == ST_WRITEBACK) && bp_stop_s;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: stimulus queues the expected retire of each
// instruction, a negedge monitor checks every WRITEBACK cycle against the queue.
module tb_cpu_sequencer;

   logic        clk;
   logic        reset;
   logic        control;
   logic        run;
   logic [2:0]  state_w;
   logic        halted_w;
   logic [5:0]  count_w;
`ifdef CPU_SEQ_BREAKPOINT_EN
   logic        bp_en;
   logic [4:0]  bp_addr;
   logic        bp_hit;
`endif

   cpu_sequencer_if #(.PC_WIDTH(5)) dp_if ();

   logic [31:0] mem [0:31];

   assign dp_if.instruction = mem[dp_if.pc];
   assign dp_if.alu_op      = dp_if.ir[14:12];
   assign dp_if.rd          = dp_if.ir[11:7];

   cpu_sequencer #(.PC_WIDTH(5), .CNT_WIDTH(6)) dut (
      .clk         (clk),
      .reset       (reset),
      .control     (control),
      .run         (run),
`ifdef CPU_SEQ_BREAKPOINT_EN
      .bp_en       (bp_en),
      .bp_addr     (bp_addr),
      .bp_hit      (bp_hit),
`endif
      .dp          (dp_if),
      .state       (state_w),
      .halted      (halted_w),
      .instr_count (count_w)
   );

   typedef struct {
      logic [4:0]  pc;
      logic        we;
      logic [31:0] ir;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   we_pulses = 0;
   int   rl_pulses = 0;
   int   bp_hits = 0;
   int   last_we_cyc = -1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endfunction

   function automatic logic [31:0] enc(input logic [2:0] op, input logic [4:0] r);
      return {17'h0_0001, op, r, 7'h13};
   endfunction

   task automatic push_exp(input logic [4:0] p, input logic w, input logic [31:0] i);
      exp_t e;
      e.pc = p;
      e.we = w;
      e.ir = i;
      sb_q.push_back(e);
   endtask

   // Monitor: every WRITEBACK cycle must match the oldest queued expectation
   always @(negedge clk) begin
      exp_t e;
      if (state_w == 3'd4) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected: writeback at pc %0h with empty queue", dp_if.pc);
         end else begin
            e = sb_q.pop_front();
            check("sb_pc", {27'd0, dp_if.pc}, {27'd0, e.pc});
            check("sb_rf_we", {31'd0, dp_if.rf_we}, {31'd0, e.we});
            check("sb_ir", dp_if.ir, e.ir);
         end
      end
      if (dp_if.rf_we) begin
         we_pulses++;
         last_we_cyc = cyc;
      end
      if (dp_if.result_load) rl_pulses++;
`ifdef CPU_SEQ_BREAKPOINT_EN
      if (bp_hit) bp_hits++;
`endif
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic init_mem();
      for (int i = 0; i < 32; i++) mem[i] = enc(3'((i % 7) + 1), 5'((i % 31) + 1));
   endtask

   task automatic do_step(input int hold, input int settle);
      control = 1'b1;
      repeat (hold) tick();
      control = 1'b0;
      repeat (settle) tick();
   endtask

   initial begin
      int c0;
      int base_we;
      int base_rl;
      int n;

      reset   = 1'b0;
      control = 1'b0;
      run     = 1'b0;
`ifdef CPU_SEQ_BREAKPOINT_EN
      bp_en   = 1'b0;
      bp_addr = 5'd0;
`endif
      init_mem();
      tick();
      tick();
      check("rst_state", {29'd0, state_w}, 32'd0);
      check("rst_pc", {27'd0, dp_if.pc}, 32'd0);
      check("rst_ir", dp_if.ir, 32'd0);
      check("rst_halted", {31'd0, halted_w}, 32'd0);
      check("rst_count", {26'd0, count_w}, 32'd0);
      check("rst_rf_we", {31'd0, dp_if.rf_we}, 32'd0);
      reset = 1'b1;
      tick();

      // Reset asserted while in WRITEBACK with a writing instruction
      mem[0] = enc(3'd3, 5'd5);
      push_exp(5'd0, 1'b0, enc(3'd3, 5'd5));
      control = 1'b1;
      tick();
      control = 1'b0;
      n = 0;
      while (state_w != 3'd4 && n < 10) begin tick(); n++; end
      check("wb_reached", {29'd0, state_w}, 32'd4);
      base_we = we_pulses;
      reset = 1'b0;
      tick();
      check("rst_mid_state", {29'd0, state_w}, 32'd0);
      check("rst_mid_rf_we", {31'd0, dp_if.rf_we}, 32'd0);
      tick();
      reset = 1'b1;
      check("rst_mid_pulses", we_pulses - base_we, 32'd0);
      check("rst_mid_pc", {27'd0, dp_if.pc}, 32'd0);
      check("rst_mid_ir", dp_if.ir, 32'd0);
      check("rst_mid_count", {26'd0, count_w}, 32'd0);
      check("rst_mid_halted", {31'd0, halted_w}, 32'd0);

      // Single step with control held for 10 cycles
      mem[0] = enc(3'd1, 5'd2);
      mem[1] = enc(3'd0, 5'd4);
      mem[2] = enc(3'd2, 5'd0);
      mem[3] = enc(3'd7, 5'd31);
      push_exp(5'd0, 1'b1, enc(3'd1, 5'd2));
      base_we = we_pulses;
      base_rl = rl_pulses;
      c0 = cyc;
      do_step(10, 1);
      check("step_we_count", we_pulses - base_we, 32'd1);
      check("step_rl_count", rl_pulses - base_rl, 32'd1);
      check("step_we_cycle", last_we_cyc, c0 + 4);
      check("step_pc", {27'd0, dp_if.pc}, 32'd1);
      check("step_count", {26'd0, count_w}, 32'd1);
      check("step_state", {29'd0, state_w}, 32'd0);

      // Write gating: alu_op=0, then rd=0, then a normal write
      push_exp(5'd1, 1'b0, enc(3'd0, 5'd4));
      push_exp(5'd2, 1'b0, enc(3'd2, 5'd0));
      push_exp(5'd3, 1'b1, enc(3'd7, 5'd31));
      base_we = we_pulses;
      do_step(1, 8);
      do_step(1, 8);
      do_step(1, 8);
      check("gate_we_count", we_pulses - base_we, 32'd1);
      check("gate_pc", {27'd0, dp_if.pc}, 32'd4);
      check("gate_count", {26'd0, count_w}, 32'd4);

      // Free-run across the pc wrap and into counter saturation
      do_reset();
      init_mem();
      for (int i = 0; i < 72; i++) push_exp(5'(i % 32), 1'b1, mem[i % 32]);
      base_we = we_pulses;
      c0 = cyc;
      run = 1'b1;
      n = 0;
      while (count_w != 6'd32 && n < 200) begin tick(); n++; end
      check("run_wrap_cycle", cyc, c0 + 129);
      check("run_wrap_pc", {27'd0, dp_if.pc}, 32'd0);
      check("run_wrap_we", we_pulses - base_we, 32'd32);
      n = 0;
      while (count_w != 6'd63 && n < 200) begin tick(); n++; end
      check("run_63_cycle", cyc, c0 + 253);
      repeat (32) tick();
      check("sat_count", {26'd0, count_w}, 32'd63);
      check("sat_pc", {27'd0, dp_if.pc}, 32'd7);
      run = 1'b0;
      repeat (8) tick();
      check("run_stop_state", {29'd0, state_w}, 32'd0);
      check("run_stop_pc", {27'd0, dp_if.pc}, 32'd8);
      check("run_stop_we", we_pulses - base_we, 32'd72);

      // HALT encoding at word 3
      do_reset();
      init_mem();
      mem[3] = 32'h0000_0000;
      for (int i = 0; i < 3; i++) push_exp(5'(i), 1'b1, mem[i]);
      c0 = cyc;
      run = 1'b1;
      n = 0;
      while (halted_w != 1'b1 && n < 40) begin tick(); n++; end
      check("halt_cycle", cyc, c0 + 14);
      check("halt_state", {29'd0, state_w}, 32'd5);
      check("halt_pc", {27'd0, dp_if.pc}, 32'd3);
      check("halt_ir", dp_if.ir, mem[2]);
      run = 1'b0;
      do_step(2, 2);
      run = 1'b1;
      do_step(1, 3);
      run = 1'b0;
      repeat (6) tick();
      check("halt_sticky", {31'd0, halted_w}, 32'd1);
      check("halt_hold_state", {29'd0, state_w}, 32'd5);
      check("halt_hold_pc", {27'd0, dp_if.pc}, 32'd3);
      check("halt_hold_count", {26'd0, count_w}, 32'd3);
      do_reset();
      check("halt_clr", {31'd0, halted_w}, 32'd0);
      check("halt_clr_state", {29'd0, state_w}, 32'd0);

`ifdef CPU_SEQ_BREAKPOINT_EN
      // Breakpoint at address 4 during free-run, then a single step resumes
      init_mem();
      bp_en   = 1'b1;
      bp_addr = 5'd4;
      for (int i = 0; i < 4; i++) push_exp(5'(i), 1'b1, mem[i]);
      n = bp_hits;
      run = 1'b1;
      c0 = 0;
      while (count_w != 6'd4 && c0 < 40) begin tick(); c0++; end
      run = 1'b0;
      check("bp_state", {29'd0, state_w}, 32'd0);
      check("bp_pc", {27'd0, dp_if.pc}, 32'd4);
      tick();
      tick();
      check("bp_hits", bp_hits - n, 32'd1);
      check("bp_idle", {29'd0, state_w}, 32'd0);
      push_exp(5'd4, 1'b1, mem[4]);
      do_step(1, 8);
      check("bp_step_pc", {27'd0, dp_if.pc}, 32'd5);
      check("bp_hits_after", bp_hits - n, 32'd1);
      bp_en = 1'b0;
`endif

      tick();
      check("sb_empty", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
